// File: rtl/fifo_rd_unpacker.sv
// Read-side stage for the registered-output synchronous FIFO: pops W-bit words
// and streams them as R symbols of W/R bits each, LSB symbol first.
module fifo_rd_unpacker #(
    parameter  int W  = 8,
    parameter  int R  = 2,
    localparam int SW = W / R,
    localparam int IW = (R > 1) ? $clog2(R) : 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          fifo_empty,
    output logic          fifo_rd_en,
    input  logic [W-1:0]  fifo_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [SW-1:0] m_data,
    output logic          m_last,
    output logic          idle
);

    logic [W-1:0]  word_buf [2];
    logic          head_ptr;
    logic          tail_ptr;
    logic          rd_pend;
    logic [1:0]    occ;
    logic [IW-1:0] sym_idx;

    logic          xfer;
    logic          last_sym;
    logic          pop_word;
    logic [2:0]    committed;

    assign last_sym = (sym_idx == IW'(R - 1));
    assign m_valid  = rstn & (occ != 2'd0);
    assign xfer     = m_valid & m_ready;
    assign pop_word = xfer & last_sym;

    // Words already buffered or in flight, net of the one leaving this cycle;
    // keeping this below 2 guarantees a slot exists when the read data lands.
    assign committed  = {1'b0, occ} + {2'b00, rd_pend} - {2'b00, pop_word};
    assign fifo_rd_en = rstn & ~fifo_empty & (committed < 3'd2);

    assign m_data = SW'(word_buf[head_ptr] >> (sym_idx * SW));
    assign m_last = last_sym;
    assign idle   = fifo_empty & (occ == 2'd0) & ~rd_pend;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            occ      <= 2'd0;
            rd_pend  <= 1'b0;
            sym_idx  <= '0;
            head_ptr <= 1'b0;
            tail_ptr <= 1'b0;
        end else begin
            rd_pend <= fifo_rd_en;
            occ     <= occ + {1'b0, rd_pend} - {1'b0, pop_word};
            if (rd_pend) begin
                tail_ptr <= ~tail_ptr;
            end
            if (pop_word) begin
                head_ptr <= ~head_ptr;
            end
            if (xfer) begin
                sym_idx <= last_sym ? '0 : sym_idx + 1'b1;
            end
        end
    end

    // NOTE: the word storage is deliberately not reset; occ guards every read,
    // so stale contents are never visible and the array maps to plain flops/RAM.
    always_ff @(posedge clk) begin
        if (rstn && rd_pend) begin
            word_buf[tail_ptr] <= fifo_data;
        end
    end

endmodule

// File: tb/tb_fifo_rd_unpacker.sv
// Bench for fifo_rd_unpacker: an R=2 and an R=1 instance, each fed by a queue
// FIFO model, with a symbol-level scoreboard built from the popped words.
module tb_fifo_rd_unpacker;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       fifo_empty [2];
    logic       fifo_rd_en [2];
    logic [7:0] fifo_data  [2];
    logic       m_valid    [2];
    logic       m_ready    [2];
    logic       m_last     [2];
    logic       idle       [2];
    logic [3:0] m_data0;
    logic [7:0] m_data1;

    logic [7:0] fq [2][$];
    logic [8:0] eq [2][$];

    int n_cmp = 0;
    int n_bad = 0;

    logic       s_rstn;
    logic       s_rd    [2];
    logic       s_valid [2];
    logic       s_hs    [2];
    logic       s_last  [2];
    logic       s_idle  [2];
    logic [7:0] s_data  [2];
    logic       p_hold  [2];
    logic       p_last  [2];
    logic [7:0] p_data  [2];

    always #5 clk = ~clk;

    fifo_rd_unpacker #(.W(8), .R(2)) dut_r2 (
        .clk        (clk),
        .rstn       (rstn),
        .fifo_empty (fifo_empty[0]),
        .fifo_rd_en (fifo_rd_en[0]),
        .fifo_data  (fifo_data[0]),
        .m_valid    (m_valid[0]),
        .m_ready    (m_ready[0]),
        .m_data     (m_data0),
        .m_last     (m_last[0]),
        .idle       (idle[0])
    );

    fifo_rd_unpacker #(.W(8), .R(1)) dut_r1 (
        .clk        (clk),
        .rstn       (rstn),
        .fifo_empty (fifo_empty[1]),
        .fifo_rd_en (fifo_rd_en[1]),
        .fifo_data  (fifo_data[1]),
        .m_valid    (m_valid[1]),
        .m_ready    (m_ready[1]),
        .m_data     (m_data1),
        .m_last     (m_last[1]),
        .idle       (idle[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Split a popped word into its expected symbols, LSB symbol first.
    task automatic expect_word(input int i, input logic [7:0] w);
        int r  = (i == 0) ? 2 : 1;
        int sw = 8 / r;
        for (int k = 0; k < r; k++) begin
            logic [7:0] sym;
            sym = 8'((w >> (k * sw)) & ((1 << sw) - 1));
            eq[i].push_back({(k == r - 1), sym});
        end
    endtask

    task automatic monitor(input int i);
        logic [7:0] d;
        logic [8:0] e;
        d = (i == 0) ? {4'h0, m_data0} : m_data1;
        s_rd[i]    = fifo_rd_en[i];
        s_valid[i] = m_valid[i];
        s_hs[i]    = m_valid[i] & m_ready[i];
        s_last[i]  = m_last[i];
        s_idle[i]  = idle[i];
        s_data[i]  = d;
        if (!s_rstn) begin
            check($sformatf("rst_rd_en[%0d]", i), fifo_rd_en[i], 0);
            check($sformatf("rst_valid[%0d]", i), m_valid[i], 0);
            p_hold[i] = 1'b0;
        end else begin
            if (fifo_rd_en[i])
                check($sformatf("rd_while_empty[%0d]", i), fifo_empty[i], 0);
            if (p_hold[i]) begin
                check($sformatf("hold_valid[%0d]", i), m_valid[i], 1);
                check($sformatf("hold_data[%0d]", i), d, p_data[i]);
                check($sformatf("hold_last[%0d]", i), m_last[i], p_last[i]);
            end
            if (s_hs[i]) begin
                if (eq[i].size() == 0) begin
                    check($sformatf("extra_symbol[%0d]", i), 1, 0);
                end else begin
                    e = eq[i].pop_front();
                    check($sformatf("sym_data[%0d]", i), d, {24'h0, e[7:0]});
                    check($sformatf("sym_last[%0d]", i), m_last[i], e[8]);
                end
            end
            p_hold[i] = m_valid[i] & ~m_ready[i];
            p_data[i] = d;
            p_last[i] = m_last[i];
        end
    endtask

    // One clock: apply inputs, sample at the falling edge, then advance the FIFO model.
    task automatic tick(input logic [1:0] rdy, input logic [1:0] stl);
        for (int i = 0; i < 2; i++) begin
            m_ready[i]    = rdy[i];
            fifo_empty[i] = (fq[i].size() == 0) || stl[i];
        end
        @(negedge clk);
        s_rstn = rstn;
        for (int i = 0; i < 2; i++) monitor(i);
        check("occ_max[0]", (dut_r2.occ == 2'd3), 0);
        check("occ_max[1]", (dut_r1.occ == 2'd3), 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (!s_rstn) begin
                eq[i].delete();
            end else if (s_rd[i] && fq[i].size() != 0) begin
                fifo_data[i] = fq[i].pop_front();
                expect_word(i, fifo_data[i]);
            end
        end
    endtask

    function automatic bit all_drained();
        return fq[0].size() == 0 && fq[1].size() == 0 && eq[0].size() == 0 &&
               eq[1].size() == 0 && s_idle[0] && s_idle[1];
    endfunction

    task automatic run_until_drained(input int budget, input bit rnd, input string tag);
        int n = 0;
        while (n < budget && !all_drained()) begin
            if (rnd)
                tick({1'($urandom), 1'($urandom)},
                     {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)});
            else
                tick(2'b11, 2'b00);
            n++;
        end
        check({tag, "_drained"}, all_drained(), 1);
    endtask

    task automatic wait_symbol(input int i, input int budget, input string tag);
        int n = 0;
        do begin
            tick(2'b11, 2'b00);
            n++;
        end while (!s_hs[i] && n < budget);
        check({tag, "_seen"}, s_hs[i], 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        for (int i = 0; i < 2; i++) begin
            fifo_data[i] = '0;
            m_ready[i]   = 1'b1;
            fifo_empty[i] = 1'b1;
            p_hold[i]    = 1'b0;
            s_idle[i]    = 1'b0;
        end

        // Reset with a non-empty FIFO, then the 0xA5 latency/order walk-through.
        rstn = 1'b0;
        fq[0].push_back(8'hA5);
        fq[1].push_back(8'h5A);
        repeat (2) begin
            tick(2'b11, 2'b00);
            check("t1_idle[0]", s_idle[0], 0);
            check("t1_idle[1]", s_idle[1], 0);
        end
        rstn = 1'b1;
        tick(2'b11, 2'b00);
        check("t1_first_rd[0]", s_rd[0], 1);
        check("t1_first_rd[1]", s_rd[1], 1);
        tick(2'b11, 2'b00);
        check("t2_valid_n1", s_valid[0], 0);
        tick(2'b11, 2'b00);
        check("t2_valid_n2", s_valid[0], 1);
        check("t2_sym0_data", s_data[0], 8'h05);
        check("t2_sym0_last", s_last[0], 0);
        tick(2'b11, 2'b00);
        check("t2_sym1_data", s_data[0], 8'h0A);
        check("t2_sym1_last", s_last[0], 1);
        run_until_drained(50, 1'b0, "t2");

        // R=1 pass-through at full rate.
        for (int k = 0; k < 16; k++) fq[1].push_back(8'(k));
        wait_symbol(1, 10, "t3_first");
        for (int k = 1; k < 16; k++) begin
            tick(2'b11, 2'b00);
            check("t3_no_bubble", s_hs[1], 1);
        end
        run_until_drained(50, 1'b0, "t3");

        // Backpressure: only two words may be fetched while the output stalls.
        for (int k = 0; k < 5; k++) fq[0].push_back(8'($urandom));
        cnt = 0;
        repeat (10) begin
            tick(2'b10, 2'b00);
            cnt += int'(s_rd[0]);
        end
        check("t4_reads", cnt, 2);
        run_until_drained(100, 1'b0, "t4");

        // Random ready and random FIFO stalls.
        for (int k = 0; k < 1000; k++) fq[0].push_back(8'($urandom));
        for (int k = 0; k < 500; k++) fq[1].push_back(8'($urandom));
        run_until_drained(20000, 1'b1, "t5");

        // Reset in the middle of word 0x3C.
        fq[0].push_back(8'h3C);
        wait_symbol(0, 10, "t6_sym0");
        check("t6_sym0_data", s_data[0], 8'h0C);
        rstn = 1'b0;
        tick(2'b11, 2'b00);
        check("t6_valid_in_rst", s_valid[0], 0);
        rstn = 1'b1;
        tick(2'b11, 2'b00);
        check("t6_valid_after_rst", s_valid[0], 0);
        fq[0].push_back(8'h81);
        wait_symbol(0, 10, "t6_next");
        check("t6_next_data", s_data[0], 8'h01);
        check("t6_next_last", s_last[0], 0);
        run_until_drained(50, 1'b0, "t6");
        check("t6_idle", s_idle[0], 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
